// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel rotator family.
// Direction encoding matches the combinational rotator's dir input.
package barrel_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} unrot_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_rot1.sv
// Combinational rotate-by-one, direction selectable.
// Building block for serial shifters.
module barrel_rot1
  import barrel_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  assign q = (dir == DIR_RIGHT) ? {d[0], d[WIDTH-1:1]}
                                : {d[WIDTH-2:0], d[WIDTH-1]};

endmodule

// File: rtl/barrel_unrotate_seq.sv
// Serial inverse of the barrel rotator: undoes a rotation one bit per clock
// in the opposite direction, with valid/ready handshakes on both sides.
module barrel_unrotate_seq
  import barrel_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   sh_amt,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  unrot_state_t     state;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   cnt_q;
  logic             undo_q;
  logic [WIDTH-1:0] rot_d;

  barrel_rot1 #(.WIDTH(WIDTH)) u_rot1 (
    .d   (data_q),
    .dir (undo_q),
    .q   (rot_d)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // dout/out_valid are loaded on the same edge that enters DONE so the
  // result is registered without an extra cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      undo_q    <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= din;
            cnt_q  <= sh_amt;
            undo_q <= ~dir;
            if (sh_amt != '0) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              dout      <= din;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= rot_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state     <= DONE;
            dout      <= rot_d;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_unrotate_seq.sv
// Directed and round-trip bench for barrel_unrotate_seq at WIDTH=4.
module tb_barrel_unrotate_seq;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   sh_amt;
  logic             dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  barrel_unrotate_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .sh_amt    (sh_amt),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] x,
                                              input int n, input logic d);
    logic [2*WIDTH-1:0] w;
    w = {x, x};
    if (n == 0) return x;
    if (d == 1'b0) return w[2*WIDTH-1-n -: WIDTH];
    return w[n +: WIDTH];
  endfunction

  // Offer a word, wait for the result, check latency/value, then drain it.
  task automatic run_word(input string tag, input logic [WIDTH-1:0] d,
                          input int sh, input logic dr,
                          input logic [WIDTH-1:0] exp, input bit chk_busy);
    int n;
    din      = d;
    sh_amt   = SHW'(sh);
    dir      = dr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      if (chk_busy) chk({tag, "_busy"}, 8'(busy), 8'd1);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 8'(n), 8'(sh + 1));
    chk({tag, "_dout"}, 8'(dout), 8'(exp));
    if (chk_busy) chk({tag, "_busy_done"}, 8'(busy), 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_fall"}, 8'(out_valid), 8'd0);
    chk({tag, "_ready_back"}, 8'(in_ready), 8'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] orig;
    int sh;
    logic dr;
    int n;

    rst = 1'b1; in_valid = 1'b0; din = '0; sh_amt = '0; dir = 1'b0; out_ready = 1'b0;
    tick();
    // Inputs presented during reset must be ignored.
    in_valid = 1'b1; din = 4'hF; sh_amt = 2'd0;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_dout", 8'(dout), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    tick();
    chk("rst_ignored", 8'(out_valid), 8'd0);

    run_word("left1", 4'b0111, 1, 1'b0, 4'b1011, 1'b0);
    run_word("right3", 4'b0111, 3, 1'b1, 4'b1011, 1'b1);
    run_word("zero", 4'b1100, 0, 1'b1, 4'b1100, 1'b0);
    run_word("left2", 4'b0001, 2, 1'b0, 4'b0100, 1'b0);

    // Backpressure: result held while a second word waits upstream.
    din = 4'b1000; sh_amt = 2'd1; dir = 1'b1; in_valid = 1'b1;
    tick();
    din = 4'b0011; sh_amt = 2'd2; dir = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_latency", 8'(n), 8'd2);
    held = dout;
    chk("bp_dout", 8'(held), 8'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_dout", 8'(dout), 8'(held));
      chk("bp_hold_ov", 8'(out_valid), 8'd1);
      chk("bp_hold_in_ready", 8'(in_ready), 8'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released_ov", 8'(out_valid), 8'd0);
    chk("bp_second_not_yet", 8'(in_ready), 8'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accepted", 8'(busy), 8'd1);
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_second_latency", 8'(n), 8'd3);
    chk("bp_second_dout", 8'(dout), 8'b1100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SHIFT drops the word.
    din = 4'b0110; sh_amt = 2'd3; dir = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_in_shift", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ov", 8'(out_valid), 8'd0);
    chk("mid_dout", 8'(dout), 8'd0);
    chk("mid_in_ready", 8'(in_ready), 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_result", 8'(out_valid), 8'd0);
    end

    // Round trip against a reference rotator.
    for (int k = 0; k < 200; k++) begin
      orig = WIDTH'($urandom_range(0, 15));
      sh   = int'($urandom_range(0, 3));
      dr   = 1'($urandom_range(0, 1));
      run_word("rt", rotate(orig, sh, dr), sh, dr, orig, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
